// File: rtl/riscv_nn_apu_arb_pkg.sv
// Shared constants and types for the APU arbiter and its tag FIFO.
package riscv_nn_apu_arb_pkg;

   localparam int NN_APU_NUM_REQ   = 4;
   localparam int NN_APU_ARB_DEPTH = 4;
   localparam int NN_APU_PAYLOAD_W = 32;
   localparam int NN_APU_ID_W      = $clog2(NN_APU_NUM_REQ);

   typedef logic [NN_APU_ID_W-1:0] apu_req_id_t;

endpackage

// File: rtl/riscv_nn_apu_tag_fifo.sv
// In-order FIFO of requester IDs for APU operations still awaiting a response.
module riscv_nn_apu_tag_fifo
   import riscv_nn_apu_arb_pkg::*;
#(
   parameter int DEPTH = NN_APU_ARB_DEPTH,
   parameter int ID_W  = NN_APU_ID_W,
   localparam int CNT_W = $clog2(DEPTH+1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [ID_W-1:0]  din_i,
   output logic [ID_W-1:0]  head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [ID_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i)
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop_i)
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i)
         mem_q[wr_ptr_q] <= din_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/riscv_nn_apu_arbiter.sv
// Round-robin arbiter sharing one APU port among several dispatchers; responses
// are routed back in issue order using a tag FIFO of requester IDs.
module riscv_nn_apu_arbiter
   import riscv_nn_apu_arb_pkg::*;
#(
   parameter int NUM_REQ   = NN_APU_NUM_REQ,
   parameter int PAYLOAD_W = NN_APU_PAYLOAD_W,
   parameter int DEPTH     = NN_APU_ARB_DEPTH,
   parameter int ID_W      = $clog2(NUM_REQ),
   localparam int CNT_W    = $clog2(DEPTH+1)
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NUM_REQ-1:0]                req_i,
   input  logic [NUM_REQ-1:0][PAYLOAD_W-1:0] payload_i,
   output logic [NUM_REQ-1:0]                gnt_o,
   output logic [NUM_REQ-1:0]                valid_o,
   output logic                              apu_req_o,
   output logic [PAYLOAD_W-1:0]              apu_payload_o,
   input  logic                              apu_gnt_i,
   input  logic                              apu_valid_i,
   output logic                              apu_ready_o,
   output logic [CNT_W-1:0]                  outstanding_o,
   output logic                              err_o
);

   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic             err_q, err_d;
   logic [ID_W-1:0]  winner;
   logic             any_req;
   logic             accept;
   logic             push, pop;
   logic [ID_W-1:0]  head;
   logic [CNT_W-1:0] count;
   logic             full, empty;

   // First requester at or after rr_ptr, wrapping around.
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         int idx;
         idx = (int'(rr_ptr_q) + i) % NUM_REQ;
         if (!any_req && req_i[idx]) begin
            any_req = 1'b1;
            winner  = ID_W'(idx);
         end
      end
   end

   always_comb begin
      apu_req_o     = any_req && !full && !rst_i;
      accept        = apu_req_o && apu_gnt_i;
      apu_payload_o = (any_req && !rst_i) ? payload_i[winner] : '0;
      gnt_o         = '0;
      valid_o       = '0;
      if (accept)
         gnt_o[winner] = 1'b1;
      // A response with nothing outstanding belongs to the op accepted this cycle.
      if (apu_valid_i && !rst_i) begin
         if (!empty)
            valid_o[head] = 1'b1;
         else if (accept)
            valid_o[winner] = 1'b1;
      end
      pop  = apu_valid_i && !empty && !rst_i;
      push = accept && !(empty && apu_valid_i);
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept)
         rr_ptr_d = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
      err_d = err_q || (apu_valid_i && empty && !accept && !rst_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_d;
      end
   end

   riscv_nn_apu_tag_fifo #(
      .DEPTH (DEPTH),
      .ID_W  (ID_W)
   ) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (winner),
      .head_o  (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   assign apu_ready_o   = 1'b1;
   assign outstanding_o = count;
   assign err_o         = err_q;

endmodule

// File: tb/tb_riscv_nn_apu_arbiter.sv
// Scoreboard bench for the APU arbiter: directed scenarios followed by random traffic.
module tb_riscv_nn_apu_arbiter;

   localparam int N  = 4;
   localparam int PW = 32;
   localparam int D  = 4;

   logic              clk = 1'b0;
   logic              rst_i;
   logic [N-1:0]      req_i;
   logic [N-1:0][PW-1:0] payload_i;
   logic [N-1:0]      gnt_o, valid_o;
   logic              apu_req_o;
   logic [PW-1:0]     apu_payload_o;
   logic              apu_gnt_i, apu_valid_i, apu_ready_o;
   logic [2:0]        outstanding_o;
   logic              err_o;

   riscv_nn_apu_arbiter #(.NUM_REQ(N), .PAYLOAD_W(PW), .DEPTH(D)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .payload_i(payload_i),
      .gnt_o(gnt_o), .valid_o(valid_o), .apu_req_o(apu_req_o),
      .apu_payload_o(apu_payload_o), .apu_gnt_i(apu_gnt_i),
      .apu_valid_i(apu_valid_i), .apu_ready_o(apu_ready_o),
      .outstanding_o(outstanding_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]  gnt;
      logic [N-1:0]  valid;
      logic          apu_req;
      logic [PW-1:0] pay;
      int            outs;
      logic          err;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state: IDs awaiting response, priority pointer, sticky error.
   int   m_tags[$];
   int   m_rr  = 0;
   bit   m_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("gnt",         32'(gnt_o),         32'(e.gnt));
         chk("valid",       32'(valid_o),       32'(e.valid));
         chk("apu_req",     32'(apu_req_o),     32'(e.apu_req));
         chk("apu_payload", apu_payload_o,      e.pay);
         chk("outstanding", 32'(outstanding_o), 32'(e.outs));
         chk("err",         32'(err_o),         32'(e.err));
         chk("apu_ready",   32'(apu_ready_o),   32'd1);
      end
   end

   task automatic cyc(input bit rst, input logic [N-1:0] req, input bit g, input bit v);
      exp_t e;
      int   w;
      bit   acc;
      @(posedge clk);
      #1;
      rst_i = rst; req_i = req; apu_gnt_i = g; apu_valid_i = v;
      for (int i = 0; i < N; i++) payload_i[i] = $urandom;
      e.gnt = '0; e.valid = '0; e.apu_req = 0; e.pay = '0;
      e.outs = m_tags.size(); e.err = m_err;
      if (rst) begin
         exp_q.push_back(e);
         m_tags.delete(); m_rr = 0; m_err = 0;
      end else begin
         w = -1;
         for (int i = 0; i < N; i++)
            if (w < 0 && req[(m_rr + i) % N]) w = (m_rr + i) % N;
         e.apu_req = (w >= 0) && (m_tags.size() < D);
         acc = e.apu_req && g;
         if (w >= 0) e.pay = payload_i[w];
         if (acc) e.gnt[w] = 1'b1;
         if (v && m_tags.size() > 0) begin
            e.valid[m_tags[0]] = 1'b1;
            void'(m_tags.pop_front());
            if (acc) m_tags.push_back(w);
         end else if (v && acc) begin
            e.valid[w] = 1'b1;
         end else begin
            if (v) m_err = 1;
            if (acc) m_tags.push_back(w);
         end
         if (acc) m_rr = (w + 1) % N;
         exp_q.push_back(e);
      end
   endtask

   initial begin
      rst_i = 1; req_i = '0; apu_gnt_i = 0; apu_valid_i = 0; payload_i = '0;
      @(posedge clk);
      cyc(1, 4'b0000, 0, 0);
      // Round-robin rotation filling the FIFO, then full stall and release.
      repeat (4) cyc(0, 4'b1111, 1, 0);
      cyc(0, 4'b1111, 1, 0);
      cyc(0, 4'b1111, 1, 1);
      cyc(0, 4'b1111, 1, 0);
      repeat (4) cyc(0, 4'b0000, 0, 1);
      // In-order routing.
      cyc(0, 4'b0100, 1, 0);
      cyc(0, 4'b0001, 1, 0);
      cyc(0, 4'b0000, 0, 0);
      cyc(0, 4'b0000, 0, 1);
      cyc(0, 4'b0000, 0, 1);
      // Single-cycle bypass.
      cyc(0, 4'b1000, 1, 1);
      // NACK hold, then push and pop together.
      repeat (3) cyc(0, 4'b0010, 0, 0);
      cyc(0, 4'b0010, 1, 0);
      cyc(0, 4'b0100, 1, 0);
      cyc(0, 4'b0010, 1, 1);
      repeat (2) cyc(0, 4'b0000, 0, 1);
      // Error, stickiness, reset with outstanding tags.
      cyc(0, 4'b0000, 0, 1);
      cyc(0, 4'b0000, 0, 0);
      repeat (3) cyc(0, 4'b1111, 1, 0);
      cyc(1, 4'b1111, 1, 1);
      cyc(0, 4'b0000, 0, 0);
      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         cyc(($urandom_range(0, 99) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0));
      end
      cyc(1, 4'b0000, 0, 0);
      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
